// File: rtl/call_stack_controller.sv
// -----------------------------------------------------------------------------
// call_stack_controller
//
// Hardware return-address stack for a single-cycle CPU. Call instructions push
// the return PC and return instructions pop it. The current top entry is shown
// combinationally, so a return resolves in the same cycle it is decoded.
// Overflow and underflow are recorded as sticky error flags, and the deepest
// occupancy since the last reset or flush is kept for debug.
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-high reset
//   stack_push      in   push push_addr this cycle
//   stack_pop       in   pop the top entry this cycle
//   flush           in   synchronous clear of the stack (pointer only)
//   push_addr       in   [ADDR_W]  return address to store
//   top_addr        out  [ADDR_W]  current top entry, 0 when empty (combinational)
//   empty           out  stack holds no entries
//   full            out  stack holds DEPTH entries
//   depth           out  [PTR_W+1] current entry count, 0..DEPTH
//   high_water      out  [PTR_W+1] maximum depth since reset or flush
//   stack_overflow  out  sticky: push attempted while full
//   stack_underflow out  sticky: pop attempted while empty
// -----------------------------------------------------------------------------
module call_stack_controller #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stack_push,
    input  logic              stack_pop,
    input  logic              flush,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr,
    output logic              empty,
    output logic              full,
    output logic [PTR_W:0]    depth,
    output logic [PTR_W:0]    high_water,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    localparam int unsigned CNT_W = PTR_W + 1;

    // Control state: entry count, high-water mark and sticky error flags.
    logic [CNT_W-1:0]  depth_q, depth_d;
    logic [CNT_W-1:0]  hw_q, hw_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    // Entry storage; contents are never reset, only the count is.
    logic [ADDR_W-1:0] mem_q [DEPTH];

    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;
    logic [PTR_W-1:0]  top_idx;
    logic              is_empty;
    logic              is_full;

    assign is_empty = (depth_q == CNT_W'(0));
    assign is_full  = (depth_q == CNT_W'(DEPTH));

    // Index of the current top entry; only meaningful when not empty.
    assign top_idx  = PTR_W'(depth_q - CNT_W'(1));

    // Next-state decode: flush wins over push/pop.
    always_comb begin
        depth_d = depth_q;
        hw_d    = hw_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_idx  = top_idx;

        if (flush) begin
            depth_d = CNT_W'(0);
            hw_d    = CNT_W'(0);
        end else begin
            unique case ({stack_push, stack_pop})
                2'b10: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = PTR_W'(depth_q);
                        depth_d = depth_q + CNT_W'(1);
                    end
                end
                2'b01: begin
                    if (is_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        depth_d = depth_q - CNT_W'(1);
                    end
                end
                2'b11: begin
                    // Tail call replaces the top in place; on an empty
                    // stack the pop half underflows and the push still lands.
                    wr_en = 1'b1;
                    if (is_empty) begin
                        wr_idx  = PTR_W'(0);
                        depth_d = CNT_W'(1);
                        unf_d   = 1'b1;
                    end else begin
                        wr_idx  = top_idx;
                    end
                end
                default: begin
                end
            endcase

            if (depth_d > hw_q) begin
                hw_d = depth_d;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            depth_q <= CNT_W'(0);
            hw_q    <= CNT_W'(0);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            hw_q    <= hw_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry write port; suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_q[wr_idx] <= push_addr;
        end
    end

    // Outputs.
    assign top_addr        = is_empty ? ADDR_W'(0) : mem_q[top_idx];
    assign empty           = is_empty;
    assign full            = is_full;
    assign depth           = depth_q;
    assign high_water      = hw_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_call_stack_controller.sv
module tb_call_stack_controller;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PTR_W  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stack_push = 1'b0;
    logic              stack_pop  = 1'b0;
    logic              flush      = 1'b0;
    logic [ADDR_W-1:0] push_addr  = '0;
    logic [ADDR_W-1:0] top_addr;
    logic              empty;
    logic              full;
    logic [PTR_W:0]    depth;
    logic [PTR_W:0]    high_water;
    logic              stack_overflow;
    logic              stack_underflow;

    int n_chk  = 0;
    int n_pass = 0;

    call_stack_controller #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .stack_push      (stack_push),
        .stack_pop       (stack_pop),
        .flush           (flush),
        .push_addr       (push_addr),
        .top_addr        (top_addr),
        .empty           (empty),
        .full            (full),
        .depth           (depth),
        .high_water      (high_water),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    always #5 clk = ~clk;

    // Reference model: the stack is a queue, top is its last element.
    logic [ADDR_W-1:0] mq[$];
    int  m_hw  = 0;
    bit  m_ovf = 1'b0;
    bit  m_unf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_hw  = 0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_hw = 0;
        end else begin
            if (stack_push && stack_pop) begin
                if (mq.size() == 0) begin
                    m_unf = 1'b1;
                    mq.push_back(push_addr);
                end else begin
                    mq[mq.size()-1] = push_addr;
                end
            end else if (stack_push) begin
                if (mq.size() == DEPTH) m_ovf = 1'b1;
                else mq.push_back(push_addr);
            end else if (stack_pop) begin
                if (mq.size() == 0) m_unf = 1'b1;
                else void'(mq.pop_back());
            end
            if (mq.size() > m_hw) m_hw = mq.size();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (!rst) begin
            logic [ADDR_W-1:0] e_top;
            logic [31:0] act_v, exp_v;
            e_top = (mq.size() == 0) ? '0 : mq[mq.size()-1];
            act_v = {top_addr, empty, full, depth, high_water, stack_overflow, stack_underflow, 8'd0};
            exp_v = {e_top, (mq.size() == 0), (mq.size() == DEPTH), 4'(mq.size()), 4'(m_hw),
                     m_ovf, m_unf, 8'd0};
            chk("model_cmp", act_v, exp_v);
        end
    end

    // One clock with the given controls; returns #1 after the edge.
    task automatic cyc(input bit p, input bit o, input bit f, input logic [ADDR_W-1:0] a);
        stack_push = p;
        stack_pop  = o;
        flush      = f;
        push_addr  = a;
        @(posedge clk);
        #1;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Async reset pulse in the middle of the low-to-high half; checks it bites before any edge.
    task automatic mid_reset(input bit check);
        #2;
        rst = 1'b1;
        #1;
        if (check) begin
            chk("async_depth", 32'(depth), 32'd0);
            chk("async_hw",    32'(high_water), 32'd0);
            chk("async_ovf",   32'(stack_overflow), 32'd0);
            chk("async_unf",   32'(stack_underflow), 32'd0);
            chk("async_empty", 32'(empty), 32'd1);
            chk("async_top",   32'(top_addr), 32'd0);
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_hw",    32'(high_water), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full",  32'(full), 32'd0);
        chk("rst_top",   32'(top_addr), 32'd0);
        chk("rst_flags", 32'({stack_overflow, stack_underflow}), 32'd0);
        rst = 1'b0;

        // Three pushes then pops down to underflow.
        cyc(1, 0, 0, 12'h010);
        cyc(1, 0, 0, 12'h020);
        cyc(1, 0, 0, 12'h030);
        chk("p3_depth", 32'(depth), 32'd3);
        chk("p3_top",   32'(top_addr), 32'h030);
        chk("p3_hw",    32'(high_water), 32'd3);
        chk("p3_empty", 32'(empty), 32'd0);
        chk("p3_flags", 32'({stack_overflow, stack_underflow}), 32'd0);
        cyc(0, 1, 0, '0);
        chk("pop1_top", 32'(top_addr), 32'h020);
        cyc(0, 1, 0, '0);
        chk("pop2_top",   32'(top_addr), 32'h010);
        chk("pop2_depth", 32'(depth), 32'd1);
        chk("pop2_hw",    32'(high_water), 32'd3);
        cyc(0, 1, 0, '0);
        chk("pop3_empty", 32'(empty), 32'd1);
        chk("pop3_top",   32'(top_addr), 32'd0);
        cyc(0, 1, 0, '0);
        chk("pop4_unf",   32'(stack_underflow), 32'd1);
        chk("pop4_depth", 32'(depth), 32'd0);

        // Fill past capacity.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 12'(12'h100 + i));
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_top",  32'(top_addr), 32'h107);
        chk("fill_ovf0", 32'(stack_overflow), 32'd0);
        cyc(1, 0, 0, 12'h108);
        chk("ovf_flag",  32'(stack_overflow), 32'd1);
        chk("ovf_top",   32'(top_addr), 32'h107);
        chk("ovf_depth", 32'(depth), 32'd8);
        cyc(0, 1, 0, '0);
        chk("ovf_pop_top", 32'(top_addr), 32'h106);
        chk("ovf_sticky",  32'(stack_overflow), 32'd1);

        // Tail-call replace at depth 2, then push+pop on empty.
        do_reset();
        cyc(1, 0, 0, 12'h010);
        cyc(1, 0, 0, 12'h020);
        cyc(1, 1, 0, 12'h0AA);
        chk("tc_depth", 32'(depth), 32'd2);
        chk("tc_top",   32'(top_addr), 32'h0AA);
        chk("tc_flags", 32'({stack_overflow, stack_underflow}), 32'd0);
        cyc(0, 1, 0, '0);
        chk("tc_under", 32'(top_addr), 32'h010);
        cyc(0, 1, 0, '0);
        cyc(1, 1, 0, 12'h055);
        chk("pe_depth", 32'(depth), 32'd1);
        chk("pe_top",   32'(top_addr), 32'h055);
        chk("pe_unf",   32'(stack_underflow), 32'd1);

        // Flush at depth 5 with a push in the same cycle.
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 12'(12'h200 + i));
        chk("fl_pre_depth", 32'(depth), 32'd5);
        cyc(1, 0, 1, 12'h3FF);
        chk("fl_depth", 32'(depth), 32'd0);
        chk("fl_hw",    32'(high_water), 32'd0);
        chk("fl_empty", 32'(empty), 32'd1);
        chk("fl_top",   32'(top_addr), 32'd0);
        chk("fl_unf",   32'(stack_underflow), 32'd1);
        chk("fl_ovf",   32'(stack_overflow), 32'd0);

        // Async reset at depth 4 with overflow set.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1, 0, 0, 12'(12'h300 + i));
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0);
        chk("ar_pre_depth", 32'(depth), 32'd4);
        chk("ar_pre_ovf",   32'(stack_overflow), 32'd1);
        mid_reset(1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            bit p, o, f;
            r = $urandom_range(99);
            p = (r < 55);
            o = ($urandom_range(99) < 50);
            f = ($urandom_range(99) < 2);
            cyc(p, o, f, 12'($urandom));
            if ($urandom_range(399) == 0) mid_reset(1'b0);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
